// File: rtl/sm3_pkg.sv
// Shared SM3 constants, state encoding and the boolean/permutation helpers
// used by the compression round and the message expansion.
package sm3_pkg;

    localparam logic [255:0] SM3_IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
    localparam logic [31:0]  T_LO   = 32'h79cc4519;
    localparam logic [31:0]  T_HI   = 32'h7a879d8a;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Word A sits in the MSBs so the struct overlays iv/hash bit-for-bit.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } sm3_state_t;

    function automatic logic [31:0] rol(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rol(x, 5'd9) ^ rol(x, 5'd17);
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rol(x, 5'd15) ^ rol(x, 5'd23);
    endfunction

    function automatic logic [31:0] ff(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z, input logic [5:0] j);
        if (j[5:4] == 2'b00) return x ^ y ^ z;
        return (x & y) | (x & z) | (y & z);
    endfunction

    function automatic logic [31:0] gg(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z, input logic [5:0] j);
        if (j[5:4] == 2'b00) return x ^ y ^ z;
        return (x & y) | (~x & z);
    endfunction

    // Rotation amount is j mod 32, i.e. the low five bits of j.
    function automatic logic [31:0] t_const(input logic [5:0] j);
        return rol((j[5:4] == 2'b00) ? T_LO : T_HI, j[4:0]);
    endfunction

endpackage

// File: rtl/sm3_cf_engine_if.sv
// Start/complete handshake plus data bus between a hash initiator and the
// SM3 compression engine.
interface sm3_cf_engine_if;
    logic         cf_start;
    logic [255:0] iv;
    logic [511:0] block;
    logic [255:0] hash;
    logic         cf_end;

    modport master (output cf_start, iv, block, input  hash, cf_end);
    modport slave  (input  cf_start, iv, block, output hash, cf_end);
endinterface

// File: rtl/sm3_round.sv
// One combinational SM3 compression round: working state A..H, round index
// and the two message words Wj / Wj+4 in, next A..H out.
module sm3_round
    import sm3_pkg::*;
(
    input  sm3_state_t  v_i,
    input  logic [5:0]  j_i,
    input  logic [31:0] wj_i,
    input  logic [31:0] wj4_i,
    output sm3_state_t  v_o
);

    logic [31:0] a_rot;
    logic [31:0] ss1;
    logic [31:0] ss2;
    logic [31:0] tt1;
    logic [31:0] tt2;

    always_comb begin
        a_rot = rol(v_i.a, 5'd12);
        ss1   = rol(a_rot + v_i.e + t_const(j_i), 5'd7);
        ss2   = ss1 ^ a_rot;
        tt1   = ff(v_i.a, v_i.b, v_i.c, j_i) + v_i.d + ss2 + (wj_i ^ wj4_i);
        tt2   = gg(v_i.e, v_i.f, v_i.g, j_i) + v_i.h + ss1 + wj_i;
        v_o   = '{a: tt1,
                  b: v_i.a,
                  c: rol(v_i.b, 5'd9),
                  d: v_i.c,
                  e: p0(tt2),
                  f: v_i.e,
                  g: rol(v_i.f, 5'd19),
                  h: v_i.g};
    end

endmodule

// File: rtl/sm3_cf_engine.sv
// Iterative SM3 compression function: one round per clock, message schedule
// expanded on the fly from a 16-word sliding window.
module sm3_cf_engine
    import sm3_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    sm3_cf_engine_if.slave bus
);

    state_e            state_q, state_d;
    logic [6:0]        j_q, j_d;
    sm3_state_t        v_q, v_d;
    sm3_state_t        work_q, work_d;
    logic [15:0][31:0] w_q, w_d;
    logic [255:0]      hash_q, hash_d;
    logic              cf_end_q, cf_end_d;

    sm3_state_t        round_out;
    logic [31:0]       w_next;

    // w_q[0] always holds Wj, so Wj+4 is w_q[4].
    sm3_round u_round (
        .v_i   (work_q),
        .j_i   (j_q[5:0]),
        .wj_i  (w_q[0]),
        .wj4_i (w_q[4]),
        .v_o   (round_out)
    );

    assign w_next = p1(w_q[0] ^ w_q[7] ^ rol(w_q[13], 5'd15)) ^ rol(w_q[3], 5'd7) ^ w_q[10];

    always_comb begin
        state_d  = state_q;
        j_d      = j_q;
        v_d      = v_q;
        work_d   = work_q;
        w_d      = w_q;
        hash_d   = hash_q;
        cf_end_d = cf_end_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.cf_start) begin
                    v_d    = bus.iv;
                    work_d = bus.iv;
                    for (int k = 0; k < 16; k++) begin
                        w_d[k] = bus.block[511 - 32*k -: 32];
                    end
                    j_d     = 7'd0;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                // j reaching 64 marks the extra finalisation edge after round 63.
                if (j_q == 7'd64) begin
                    hash_d   = v_q ^ work_q;
                    cf_end_d = 1'b1;
                    j_d      = 7'd0;
                    state_d  = ST_DONE;
                end else begin
                    work_d = round_out;
                    w_d    = {w_next, w_q[15:1]};
                    j_d    = j_q + 7'd1;
                end
            end
            ST_DONE: begin
                if (!bus.cf_start) begin
                    cf_end_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            j_q      <= '0;
            v_q      <= '0;
            work_q   <= '0;
            w_q      <= '0;
            hash_q   <= '0;
            cf_end_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            j_q      <= j_d;
            v_q      <= v_d;
            work_q   <= work_d;
            w_q      <= w_d;
            hash_q   <= hash_d;
            cf_end_q <= cf_end_d;
        end
    end

    assign bus.hash   = hash_q;
    assign bus.cf_end = cf_end_q;

endmodule

// File: tb/tb_sm3_cf_engine.sv
// Scoreboard bench for sm3_cf_engine: the driver queues expected digests and
// start edges, a negedge monitor checks each cf_end rise against them.
module tb_sm3_cf_engine;
    import sm3_pkg::*;

    localparam logic [511:0] BLK_ABC = {32'h61626380, 416'h0, 32'h00000000, 32'h00000018};
    localparam logic [511:0] BLK_A   = {16{32'h61616161}};
    localparam logic [255:0] DIG_ABC = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;

    typedef struct {
        logic [255:0] hash;
        int           start_edge;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    sm3_cf_engine_if bus ();

    sm3_cf_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Independent reference: full 68/64-word schedule, no sliding window.
    function automatic logic [31:0] r32(input logic [31:0] x, input int n);
        if (n == 0) return x;
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [255:0] sm3_ref(input logic [255:0] v, input logic [511:0] b);
        logic [31:0] w [68];
        logic [31:0] a, bb, c, d, e, f, g, h, t, ss1, ss2, tt1, tt2;
        for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 68; i++) begin
            t    = w[i-16] ^ w[i-9] ^ r32(w[i-3], 15);
            w[i] = t ^ r32(t, 15) ^ r32(t, 23) ^ r32(w[i-13], 7) ^ w[i-6];
        end
        {a, bb, c, d, e, f, g, h} = v;
        for (int j = 0; j < 64; j++) begin
            t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
            ss1 = r32(r32(a, 12) + e + r32(t, j % 32), 7);
            ss2 = ss1 ^ r32(a, 12);
            tt1 = ((j < 16) ? (a ^ bb ^ c) : ((a & bb) | (a & c) | (bb & c))) + d + ss2 + (w[j] ^ w[j+4]);
            tt2 = ((j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g))) + h + ss1 + w[j];
            d  = c;
            c  = r32(bb, 9);
            bb = a;
            a  = tt1;
            h  = g;
            g  = r32(f, 19);
            f  = e;
            e  = tt2 ^ r32(tt2, 9) ^ r32(tt2, 17);
        end
        return v ^ {a, bb, c, d, e, f, g, h};
    endfunction

    // Monitor: every cf_end rise must match the oldest queued job.
    // Latency 65 = start edge counted as edge 1, cf_end registered on edge 66.
    initial begin
        logic end_prev;
        exp_t e;
        end_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.cf_end === 1'b1 && end_prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_cf_end at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("digest", bus.hash, e.hash);
                    check_int("latency", cyc - e.start_edge, 65);
                end
            end
            end_prev = bus.cf_end;
        end
    end

    // Called right after a negedge; the next posedge is the sampling edge.
    task automatic start_job(input logic [255:0] v, input logic [511:0] b,
                             input logic [255:0] exp, input bit push);
        exp_t e;
        bus.iv       = v;
        bus.block    = b;
        bus.cf_start = 1'b1;
        e.hash       = exp;
        e.start_edge = cyc + 1;
        if (push) exp_q.push_back(e);
    endtask

    task automatic wait_end();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.cf_end === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout waiting for cf_end");
        end
    endtask

    task automatic release_job(input string name);
        bus.cf_start = 1'b0;
        @(negedge clk);
        check_int(name, int'(bus.cf_end), 0);
    endtask

    initial begin
        int highs;
        logic [255:0] dig_b;
        bus.cf_start = 1'b0;
        bus.iv       = '0;
        bus.block    = '0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_hash", bus.hash, '0);
        check_int("reset_cf_end", int'(bus.cf_end), 0);
        reset = 1'b0;
        @(negedge clk);

        // "abc" digest, then cf_start held 10 cycles into DONE
        start_job(SM3_IV, BLK_ABC, DIG_ABC, 1'b1);
        wait_end();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_int("hold_cf_end", int'(bus.cf_end), 1);
            check("hold_hash", bus.hash, DIG_ABC);
            check_int("hold_state", int'(dut.state_q), int'(ST_DONE));
        end
        release_job("release_cf_end");
        check_int("idle_after_release", int'(dut.state_q), int'(ST_IDLE));
        highs = 0;
        repeat (70) begin
            @(negedge clk);
            if (bus.cf_end === 1'b1) highs++;
        end
        check_int("no_second_job", highs, 0);
        check("hash_kept", bus.hash, DIG_ABC);

        // inputs changed one cycle after the latching edge
        start_job(SM3_IV, BLK_ABC, DIG_ABC, 1'b1);
        @(negedge clk);
        bus.block = '1;
        bus.iv    = '0;
        wait_end();
        release_job("late_change_release");

        // reset at round j=30 with cf_start still high on that edge
        start_job(SM3_IV, BLK_ABC, DIG_ABC, 1'b0);
        repeat (31) @(negedge clk);
        check_int("j_before_reset", int'(dut.j_q), 30);
        reset = 1'b1;
        @(negedge clk);
        check_int("rst_cf_end", int'(bus.cf_end), 0);
        check("rst_hash", bus.hash, '0);
        check_int("rst_state", int'(dut.state_q), int'(ST_IDLE));
        check_int("rst_j", int'(dut.j_q), 0);
        reset        = 1'b0;
        bus.cf_start = 1'b0;
        @(negedge clk);
        check_int("no_start_under_reset", int'(dut.state_q), int'(ST_IDLE));
        start_job(SM3_IV, BLK_ABC, DIG_ABC, 1'b1);
        wait_end();
        release_job("post_reset_release");

        // back-to-back jobs, second chained on the first digest
        dig_b = sm3_ref(DIG_ABC, BLK_A);
        start_job(SM3_IV, BLK_ABC, DIG_ABC, 1'b1);
        wait_end();
        release_job("b2b_first_release");
        start_job(DIG_ABC, BLK_A, dig_b, 1'b1);
        wait_end();
        release_job("b2b_second_release");

        // single-cycle start pulse
        start_job(SM3_IV, BLK_ABC, DIG_ABC, 1'b1);
        @(negedge clk);
        bus.cf_start = 1'b0;
        wait_end();
        @(negedge clk);
        check_int("pulse_cf_end_one_cycle", int'(bus.cf_end), 0);

        repeat (3) @(negedge clk);
        check_int("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
